// File: rtl/cram_arbiter_if.sv
// Bus bundle for cram_arbiter: three requester channels (cpu, ss, bk), the
// single-port cart RAM command/data pins and the busy flag.
//   slave  : arbiter side (takes requests, drives acks/rdata/RAM command)
//   master : environment side (drives requests, models the RAM)
interface cram_arbiter_if #(
  parameter int unsigned AW = 17,
  parameter int unsigned DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          ss_req;
  logic          ss_we;
  logic [AW-1:0] ss_addr;
  logic [DW-1:0] ss_wdata;
  logic          ss_ack;
  logic [DW-1:0] ss_rdata;

  logic          bk_req;
  logic          bk_we;
  logic [AW-1:0] bk_addr;
  logic [DW-1:0] bk_wdata;
  logic          bk_ack;
  logic [DW-1:0] bk_rdata;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ss_req, ss_we, ss_addr, ss_wdata,
    input  bk_req, bk_we, bk_addr, bk_wdata,
    input  ram_rdata,
    output cpu_ack, cpu_rdata, ss_ack, ss_rdata, bk_ack, bk_rdata,
    output ram_addr, ram_we, ram_wdata, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ss_req, ss_we, ss_addr, ss_wdata,
    output bk_req, bk_we, bk_addr, bk_wdata,
    output ram_rdata,
    input  cpu_ack, cpu_rdata, ss_ack, ss_rdata, bk_ack, bk_rdata,
    input  ram_addr, ram_we, ram_wdata, busy
  );
endinterface

// File: rtl/cram_arbiter.sv
// Cart RAM arbiter: shares one single-port RAM between the CPU mapper (cpu),
// the savestate engine (ss) and SD backup load/save (bk).
// One access per IDLE -> ISSUE -> DONE pass; fixed priority cpu > ss > bk.
// Ports:
//   clk_sys  system clock (rising edge)
//   reset_n  asynchronous active-low reset
//   bus      cram_arbiter_if.slave (requester channels, RAM pins, busy)
// Build option: CRAM_ARB_STARVE_GUARD_EN adds a starvation counter that hands
// the slot to ss (else bk) after STARVE_MAX back-to-back CPU grants.
// Read data registers update on the edge that closes DONE, so a requester's
// rdata is valid from the cycle after its ack.
module cram_arbiter #(
  parameter int unsigned AW         = 17,
  parameter int unsigned DW         = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  cram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_e;
  typedef enum logic [1:0] {GNT_CPU, GNT_SS, GNT_BK}    gnt_e;

  state_e        state_q, state_d;
  gnt_e          gnt_q, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          ram_we_q, ram_we_d;
  logic [2:0]    ack_q, ack_d;          // {bk, ss, cpu}
  logic [DW-1:0] rdata_cpu_q, rdata_cpu_d;
  logic [DW-1:0] rdata_ss_q, rdata_ss_d;
  logic [DW-1:0] rdata_bk_q, rdata_bk_d;
  logic          busy_q, busy_d;
  logic          grant_c;
  logic          force_other_c;

  // Arbitration, field latching and per-state outputs
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    ack_d       = 3'b000;
    rdata_cpu_d = rdata_cpu_q;
    rdata_ss_d  = rdata_ss_q;
    rdata_bk_d  = rdata_bk_q;
    grant_c     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_req || bus.ss_req || bus.bk_req) begin
          grant_c = 1'b1;
          state_d = ST_ISSUE;
          if (force_other_c && bus.ss_req)      gnt_d = GNT_SS;
          else if (force_other_c && bus.bk_req) gnt_d = GNT_BK;
          else if (bus.cpu_req)                 gnt_d = GNT_CPU;
          else if (bus.ss_req)                  gnt_d = GNT_SS;
          else                                  gnt_d = GNT_BK;
          // ram_addr/ram_wdata registers double as the latched request fields
          case (gnt_d)
            GNT_CPU: begin
              we_d        = bus.cpu_we;
              ram_addr_d  = bus.cpu_addr;
              ram_wdata_d = bus.cpu_wdata;
            end
            GNT_SS: begin
              we_d        = bus.ss_we;
              ram_addr_d  = bus.ss_addr;
              ram_wdata_d = bus.ss_wdata;
            end
            default: begin
              we_d        = bus.bk_we;
              ram_addr_d  = bus.bk_addr;
              ram_wdata_d = bus.bk_wdata;
            end
          endcase
          ram_we_d = we_d;
        end
      end
      ST_ISSUE: begin
        state_d = ST_DONE;
        case (gnt_q)
          GNT_CPU: ack_d[0] = 1'b1;
          GNT_SS:  ack_d[1] = 1'b1;
          default: ack_d[2] = 1'b1;
        endcase
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (!we_q) begin
          case (gnt_q)
            GNT_CPU: rdata_cpu_d = bus.ram_rdata;
            GNT_SS:  rdata_ss_d  = bus.ram_rdata;
            default: rdata_bk_d  = bus.ram_rdata;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= GNT_CPU;
      we_q        <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ack_q       <= 3'b000;
      rdata_cpu_q <= '0;
      rdata_ss_q  <= '0;
      rdata_bk_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
      ack_q       <= ack_d;
      rdata_cpu_q <= rdata_cpu_d;
      rdata_ss_q  <= rdata_ss_d;
      rdata_bk_q  <= rdata_bk_d;
      busy_q      <= busy_d;
    end
  end

`ifdef CRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_q, starve_d;

  assign force_other_c = (starve_q == CW'(STARVE_MAX));

  // Counts CPU grants taken while another requester is waiting
  always_comb begin
    starve_d = starve_q;
    if (!bus.ss_req && !bus.bk_req) begin
      starve_d = '0;
    end else if (grant_c) begin
      starve_d = (gnt_d == GNT_CPU) ? starve_q + CW'(1) : '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end
`else
  assign force_other_c = 1'b0;
`endif

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.cpu_ack   = ack_q[0];
  assign bus.ss_ack    = ack_q[1];
  assign bus.bk_ack    = ack_q[2];
  assign bus.cpu_rdata = rdata_cpu_q;
  assign bus.ss_rdata  = rdata_ss_q;
  assign bus.bk_rdata  = rdata_bk_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cram_arbiter.sv
// Self-checking bench for cram_arbiter: table of per-cycle vectors plus
// hand-written sequences for mid-transaction reset and CPU starvation.
module tb_cram_arbiter;
  localparam int unsigned AW     = 17;
  localparam int unsigned DW     = 8;
  localparam int unsigned STARVE = 4;

  logic clk_sys = 1'b0;
  logic reset_n;
  always #5 clk_sys = ~clk_sys;

  cram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  cram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Synchronous RAM model: read data valid one cycle after the address
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h expected %h at %0t", name, row, act, exp, $time);
    end
  endtask

  // Ack exclusivity and ack/ram_we placement, every cycle out of reset
  always @(negedge clk_sys) begin
    if (reset_n === 1'b1) begin
      chk("ack_onehot", -1, 32'($onehot0({bus.bk_ack, bus.ss_ack, bus.cpu_ack})), 32'd1);
      chk("ack_vs_we", -1, 32'((bus.cpu_ack | bus.ss_ack | bus.bk_ack) & (bus.ram_we | ~bus.busy)), 32'd0);
    end
  end

  typedef struct {
    logic [2:0]    req;    // {bk, ss, cpu}
    logic [2:0]    we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    exp_ack;
    logic          exp_we;
    logic          exp_busy;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_rc;
    logic [DW-1:0] exp_rs;
    logic [DW-1:0] exp_rb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] req, input logic [2:0] we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, input logic [2:0] ack, input logic rwe,
                              input logic busy, input logic [AW-1:0] eaddr,
                              input logic [DW-1:0] rc, input logic [DW-1:0] rs, input logic [DW-1:0] rb);
    vec_t v;
    v.req = req; v.we = we; v.addr = addr; v.wdata = wd;
    v.exp_ack = ack; v.exp_we = rwe; v.exp_busy = busy; v.exp_addr = eaddr;
    v.exp_rc = rc; v.exp_rs = rs; v.exp_rb = rb;
    return v;
  endfunction

  task automatic drive(input logic [2:0] req, input logic [2:0] we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpu_req = req[0]; bus.cpu_we = we[0]; bus.cpu_addr = a; bus.cpu_wdata = d;
    bus.ss_req  = req[1]; bus.ss_we  = we[1]; bus.ss_addr  = a; bus.ss_wdata  = d;
    bus.bk_req  = req[2]; bus.bk_we  = we[2]; bus.bk_addr  = a; bus.bk_wdata  = d;
  endtask

  logic [1:0] got [0:15];
  int         nack;
  logic [1:0] exp_g;

  initial begin
    // Rows: inputs driven before an edge, outputs expected after it
    vecs.push_back(mk(3'b000, 3'b000, 17'h10, 8'h00, 3'b000, 0, 0, 17'h00, 8'h00, 8'h00, 8'h00));
    // CPU write 0xA5 @0x10, then CPU read back
    vecs.push_back(mk(3'b001, 3'b001, 17'h10, 8'hA5, 3'b000, 1, 1, 17'h10, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(3'b000, 3'b000, 17'h10, 8'h00, 3'b001, 0, 1, 17'h10, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(3'b000, 3'b000, 17'h10, 8'h00, 3'b000, 0, 0, 17'h10, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(3'b001, 3'b000, 17'h10, 8'h00, 3'b000, 0, 1, 17'h10, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(3'b000, 3'b000, 17'h10, 8'h00, 3'b001, 0, 1, 17'h10, 8'h00, 8'h00, 8'h00));
    vecs.push_back(mk(3'b000, 3'b000, 17'h10, 8'h00, 3'b000, 0, 0, 17'h10, 8'hA5, 8'h00, 8'h00));
    // All three request together, each drops after its own ack
    vecs.push_back(mk(3'b111, 3'b000, 17'h10, 8'h00, 3'b000, 0, 1, 17'h10, 8'hA5, 8'h00, 8'h00));
    vecs.push_back(mk(3'b111, 3'b000, 17'h10, 8'h00, 3'b001, 0, 1, 17'h10, 8'hA5, 8'h00, 8'h00));
    vecs.push_back(mk(3'b110, 3'b000, 17'h10, 8'h00, 3'b000, 0, 0, 17'h10, 8'hA5, 8'h00, 8'h00));
    vecs.push_back(mk(3'b110, 3'b000, 17'h10, 8'h00, 3'b000, 0, 1, 17'h10, 8'hA5, 8'h00, 8'h00));
    vecs.push_back(mk(3'b110, 3'b000, 17'h10, 8'h00, 3'b010, 0, 1, 17'h10, 8'hA5, 8'h00, 8'h00));
    vecs.push_back(mk(3'b100, 3'b000, 17'h10, 8'h00, 3'b000, 0, 0, 17'h10, 8'hA5, 8'hA5, 8'h00));
    vecs.push_back(mk(3'b100, 3'b000, 17'h10, 8'h00, 3'b000, 0, 1, 17'h10, 8'hA5, 8'hA5, 8'h00));
    vecs.push_back(mk(3'b100, 3'b000, 17'h10, 8'h00, 3'b100, 0, 1, 17'h10, 8'hA5, 8'hA5, 8'h00));
    vecs.push_back(mk(3'b000, 3'b000, 17'h10, 8'h00, 3'b000, 0, 0, 17'h10, 8'hA5, 8'hA5, 8'hA5));
    // ss write 0x5C @0x1F (ss_rdata must hold)
    vecs.push_back(mk(3'b010, 3'b010, 17'h1F, 8'h5C, 3'b000, 1, 1, 17'h1F, 8'hA5, 8'hA5, 8'hA5));
    vecs.push_back(mk(3'b000, 3'b000, 17'h1F, 8'h00, 3'b010, 0, 1, 17'h1F, 8'hA5, 8'hA5, 8'hA5));
    vecs.push_back(mk(3'b000, 3'b000, 17'h1F, 8'h00, 3'b000, 0, 0, 17'h1F, 8'hA5, 8'hA5, 8'hA5));
    // bk read @0x1F, address changes to 0x10 during ISSUE
    vecs.push_back(mk(3'b100, 3'b000, 17'h1F, 8'h00, 3'b000, 0, 1, 17'h1F, 8'hA5, 8'hA5, 8'hA5));
    vecs.push_back(mk(3'b100, 3'b000, 17'h10, 8'h00, 3'b100, 0, 1, 17'h1F, 8'hA5, 8'hA5, 8'hA5));
    vecs.push_back(mk(3'b000, 3'b000, 17'h10, 8'h00, 3'b000, 0, 0, 17'h1F, 8'hA5, 8'hA5, 8'h5C));
    // CPU read @0x1F
    vecs.push_back(mk(3'b001, 3'b000, 17'h1F, 8'h00, 3'b000, 0, 1, 17'h1F, 8'hA5, 8'hA5, 8'h5C));
    vecs.push_back(mk(3'b000, 3'b000, 17'h1F, 8'h00, 3'b001, 0, 1, 17'h1F, 8'hA5, 8'hA5, 8'h5C));
    vecs.push_back(mk(3'b000, 3'b000, 17'h1F, 8'h00, 3'b000, 0, 0, 17'h1F, 8'h5C, 8'hA5, 8'h5C));
    // CPU holds req through its ack: two back-to-back reads @0x10
    vecs.push_back(mk(3'b001, 3'b000, 17'h10, 8'h00, 3'b000, 0, 1, 17'h10, 8'h5C, 8'hA5, 8'h5C));
    vecs.push_back(mk(3'b001, 3'b000, 17'h10, 8'h00, 3'b001, 0, 1, 17'h10, 8'h5C, 8'hA5, 8'h5C));
    vecs.push_back(mk(3'b001, 3'b000, 17'h10, 8'h00, 3'b000, 0, 0, 17'h10, 8'hA5, 8'hA5, 8'h5C));
    vecs.push_back(mk(3'b001, 3'b000, 17'h10, 8'h00, 3'b000, 0, 1, 17'h10, 8'hA5, 8'hA5, 8'h5C));
    vecs.push_back(mk(3'b000, 3'b000, 17'h10, 8'h00, 3'b001, 0, 1, 17'h10, 8'hA5, 8'hA5, 8'h5C));
    vecs.push_back(mk(3'b000, 3'b000, 17'h10, 8'h00, 3'b000, 0, 0, 17'h10, 8'hA5, 8'hA5, 8'h5C));

    mem[17'h33] = 8'h00;
    reset_n = 1'b0;
    drive(3'b000, 3'b000, '0, '0);
    repeat (2) @(posedge clk_sys);
    #1;
    chk("rst_busy", -1, 32'(bus.busy), 32'd0);
    chk("rst_we", -1, 32'(bus.ram_we), 32'd0);
    chk("rst_acks", -1, 32'({bus.bk_ack, bus.ss_ack, bus.cpu_ack}), 32'd0);
    chk("rst_addr", -1, 32'(bus.ram_addr), 32'd0);
    chk("rst_rdata", -1, 32'({bus.cpu_rdata, bus.ss_rdata, bus.bk_rdata}), 32'd0);
    @(negedge clk_sys);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk_sys);
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      @(posedge clk_sys);
      #1;
      chk("acks", i, 32'({bus.bk_ack, bus.ss_ack, bus.cpu_ack}), 32'(vecs[i].exp_ack));
      chk("ram_we", i, 32'(bus.ram_we), 32'(vecs[i].exp_we));
      chk("busy", i, 32'(bus.busy), 32'(vecs[i].exp_busy));
      chk("ram_addr", i, 32'(bus.ram_addr), 32'(vecs[i].exp_addr));
      chk("cpu_rdata", i, 32'(bus.cpu_rdata), 32'(vecs[i].exp_rc));
      chk("ss_rdata", i, 32'(bus.ss_rdata), 32'(vecs[i].exp_rs));
      chk("bk_rdata", i, 32'(bus.bk_rdata), 32'(vecs[i].exp_rb));
    end

    // Reset during ISSUE of an ss write, CPU request held across reset
    @(negedge clk_sys);
    drive(3'b010, 3'b010, 17'h33, 8'h77);
    @(posedge clk_sys);
    #1;
    chk("rs_issue_we", 100, 32'(bus.ram_we), 32'd1);
    chk("rs_issue_addr", 100, 32'(bus.ram_addr), 32'h33);
    #1;
    drive(3'b001, 3'b000, 17'h10, 8'h00);
    reset_n = 1'b0;
    #1;
    chk("rs_we_drop", 101, 32'(bus.ram_we), 32'd0);
    chk("rs_busy", 101, 32'(bus.busy), 32'd0);
    chk("rs_addr", 101, 32'(bus.ram_addr), 32'd0);
    chk("rs_rdata", 101, 32'({bus.cpu_rdata, bus.ss_rdata, bus.bk_rdata}), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_sys);
      #1;
      chk("rs_no_ack", 102 + c, 32'({bus.bk_ack, bus.ss_ack, bus.cpu_ack}), 32'd0);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("rs_grant_busy", 104, 32'(bus.busy), 32'd1);
    chk("rs_grant_addr", 104, 32'(bus.ram_addr), 32'h10);
    chk("rs_grant_ack", 104, 32'({bus.bk_ack, bus.ss_ack, bus.cpu_ack}), 32'd0);
    @(negedge clk_sys);
    drive(3'b000, 3'b000, 17'h10, 8'h00);
    @(posedge clk_sys);
    #1;
    chk("rs_cpu_ack", 105, 32'({bus.bk_ack, bus.ss_ack, bus.cpu_ack}), 32'b001);
    @(posedge clk_sys);
    #1;
    chk("rs_idle", 106, 32'(bus.busy), 32'd0);
    chk("rs_mem_untouched", 106, 32'(mem[17'h33]), 32'h00);

    // CPU and ss both held high: record the first ten acks
    @(negedge clk_sys);
    drive(3'b011, 3'b000, 17'h10, 8'h00);
    nack = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk_sys);
      #1;
      if (nack < 16) begin
        if (bus.cpu_ack) begin got[nack] = 2'd0; nack++; end
        else if (bus.ss_ack) begin got[nack] = 2'd1; nack++; end
        else if (bus.bk_ack) begin got[nack] = 2'd2; nack++; end
      end
    end
    chk("starve_nack", 200, 32'(nack), 32'd10);
    for (int i = 0; i < 10 && i < nack; i++) begin
`ifdef CRAM_ARB_STARVE_GUARD_EN
      exp_g = ((i % (STARVE + 1)) == STARVE) ? 2'd1 : 2'd0;
`else
      exp_g = 2'd0;
`endif
      chk("starve_order", 200 + i, 32'(got[i]), 32'(exp_g));
    end
    @(negedge clk_sys);
    drive(3'b000, 3'b000, '0, '0);
    repeat (4) @(posedge clk_sys);
    #1;
    chk("final_idle", 300, 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
